// File: rtl/line_unpacker_pkg.sv
// rtl/line_unpacker_pkg.sv - shared types and helpers for the line unpacker
//
// Purpose: FSM state encoding, performance counter type and a saturating
//          increment used by the optional performance counters.
// Ports:   none (package).

package line_unpacker_pkg;

  localparam int PERF_CNT_W = 32;

  typedef logic [PERF_CNT_W-1:0] perf_cnt_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  // Counters stick at all-ones instead of wrapping to zero.
  function automatic perf_cnt_t sat_inc(input perf_cnt_t v, input logic en);
    if (en && (v != '1)) begin
      return v + perf_cnt_t'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/line_unpacker_if.sv
// rtl/line_unpacker_if.sv - wide-line in / narrow-beat out handshake bundle
//
// Purpose: groups the input line handshake and the output beat handshake.
// Modports:
//   master - environment side: drives in_valid/in_data/out_ready.
//   slave  - unpacker side: drives in_ready/out_valid/out_data/out_idx/out_last.

interface line_unpacker_if #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64,
  parameter int IDX_W     = $clog2(IN_WIDTH / OUT_WIDTH)
);

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/line_unpacker_perf_cnt.sv
// rtl/line_unpacker_perf_cnt.sv - saturating line/beat/stall counters
//
// Purpose: counts accepted lines, emitted beats and output stall cycles.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_fire_in      input line handshake this cycle
//   i_fire_out     output beat handshake this cycle
//   i_stall        beat offered but not taken this cycle
//   o_perf_lines   saturating count of i_fire_in
//   o_perf_beats   saturating count of i_fire_out
//   o_perf_stall   saturating count of i_stall

module line_unpacker_perf_cnt
  import line_unpacker_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_fire_in,
  input  logic      i_fire_out,
  input  logic      i_stall,
  output perf_cnt_t o_perf_lines,
  output perf_cnt_t o_perf_beats,
  output perf_cnt_t o_perf_stall
);

  perf_cnt_t r_perf_lines;
  perf_cnt_t r_perf_beats;
  perf_cnt_t r_perf_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_lines <= '0;
      r_perf_beats <= '0;
      r_perf_stall <= '0;
    end else begin
      r_perf_lines <= sat_inc(r_perf_lines, i_fire_in);
      r_perf_beats <= sat_inc(r_perf_beats, i_fire_out);
      r_perf_stall <= sat_inc(r_perf_stall, i_stall);
    end
  end

  assign o_perf_lines = r_perf_lines;
  assign o_perf_beats = r_perf_beats;
  assign o_perf_stall = r_perf_stall;

endmodule

// File: rtl/line_unpacker.sv
// rtl/line_unpacker.sv - wide line to narrow beat width down-converter
//
// Purpose: accepts one IN_WIDTH line per handshake and replays it as
//          RATIO = IN_WIDTH/OUT_WIDTH beats, least-significant slice first,
//          with no bubble between consecutive lines.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   bus (slave)    in_valid/in_ready/in_data line input,
//                  out_valid/out_ready/out_data/out_idx/out_last beat output
//   o_perf_lines/o_perf_beats/o_perf_stall  present only with
//                  LINE_UNPACKER_PERF_CNT_EN defined
// Macro: LINE_UNPACKER_PERF_CNT_EN enables the performance counters.

module line_unpacker
  import line_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64,
  parameter int IDX_W     = $clog2(IN_WIDTH / OUT_WIDTH)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  line_unpacker_if.slave bus
`ifdef LINE_UNPACKER_PERF_CNT_EN
  ,
  output perf_cnt_t      o_perf_lines,
  output perf_cnt_t      o_perf_beats,
  output perf_cnt_t      o_perf_stall
`endif
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;

  if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0) ||
      ((RATIO * OUT_WIDTH) != IN_WIDTH) || (IDX_W != $clog2(RATIO))) begin : g_bad_cfg
    $error("line_unpacker: IN_WIDTH/OUT_WIDTH must be a power of two >= 2");
  end

  state_t                           r_state;
  logic [IDX_W-1:0]                 r_cnt;
  logic [IN_WIDTH-1:0]              r_hold;

  logic                             w_busy;
  logic                             w_last;
  logic                             w_fire_in;
  logic                             w_fire_out;
  logic [RATIO-1:0][OUT_WIDTH-1:0]  w_slices;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_last     = w_busy && (r_cnt == IDX_W'(RATIO - 1));
  assign w_fire_out = w_busy && bus.out_ready;
  assign w_fire_in  = bus.in_valid && bus.in_ready;

  // Ready depends on out_ready (line drains this cycle) but never on in_valid.
  assign bus.in_ready  = !w_busy || (w_fire_out && w_last);
  assign bus.out_valid = w_busy;
  assign bus.out_idx   = r_cnt;
  assign bus.out_last  = w_last;

  // Slice 0 occupies the least-significant bits of the line.
  assign w_slices     = r_hold;
  assign bus.out_data = w_slices[r_cnt];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_fire_in) begin
            r_state <= ST_BUSY;
            r_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (w_fire_out) begin
            if (!w_last) begin
              r_cnt <= r_cnt + IDX_W'(1);
            end else begin
              // Wrap explicitly; a new line on the same edge keeps us busy.
              r_cnt <= '0;
              if (!w_fire_in) begin
                r_state <= ST_EMPTY;
              end
            end
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Line storage carries no reset; out_data is meaningless while idle.
  always_ff @(posedge i_clk) begin
    if (w_fire_in) begin
      r_hold <= bus.in_data;
    end
  end

`ifdef LINE_UNPACKER_PERF_CNT_EN
  line_unpacker_perf_cnt u_perf_cnt (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_fire_in    (w_fire_in),
    .i_fire_out   (w_fire_out),
    .i_stall      (w_busy && !bus.out_ready),
    .o_perf_lines (o_perf_lines),
    .o_perf_beats (o_perf_beats),
    .o_perf_stall (o_perf_stall)
  );
`endif

`ifndef SYNTHESIS
  // A line may only land while idle or while the last beat leaves.
  a_no_overwrite: assert property (@(posedge i_clk) disable iff (i_rst)
    w_fire_in |-> (!w_busy || (w_fire_out && w_last)));

  // An offered beat stays offered until taken.
  a_valid_held: assert property (@(posedge i_clk) disable iff (i_rst)
    (w_busy && !w_fire_out) |=> w_busy);
`endif

endmodule

// File: tb/tb_line_unpacker.sv
// tb/tb_line_unpacker.sv - directed self-checking bench for line_unpacker

module tb_line_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  line_unpacker_if #(.IN_WIDTH(512), .OUT_WIDTH(64)) bus_if ();

`ifdef LINE_UNPACKER_PERF_CNT_EN
  logic [31:0] perf_lines;
  logic [31:0] perf_beats;
  logic [31:0] perf_stall;
`endif

  line_unpacker #(.IN_WIDTH(512), .OUT_WIDTH(64)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus_if)
`ifdef LINE_UNPACKER_PERF_CNT_EN
    ,
    .o_perf_lines (perf_lines),
    .o_perf_beats (perf_beats),
    .o_perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] tag);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = tag + 64'(k);
    return l;
  endfunction

  task automatic check_beat(input string tag, input int k, input logic [63:0] ltag, input logic rdy_exp);
    check_vec($sformatf("%s_valid%0d", tag, k), 64'(bus_if.out_valid), 64'd1);
    check_vec($sformatf("%s_idx%0d", tag, k), 64'(bus_if.out_idx), 64'(k));
    check_vec($sformatf("%s_data%0d", tag, k), bus_if.out_data, ltag + 64'(k));
    check_vec($sformatf("%s_last%0d", tag, k), 64'(bus_if.out_last), 64'(k == 7));
    check_vec($sformatf("%s_rdy%0d", tag, k), 64'(bus_if.in_ready), 64'(rdy_exp));
  endtask

  initial begin
    logic [63:0] t;
    int ln;
    int k;

    // Reset with a line offered: nothing may be taken or shown.
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = mk_line(64'hDEAD_0000_0000_0000);
    bus_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_vec("rst_valid", 64'(bus_if.out_valid), 64'd0);
    check_vec("rst_ready", 64'(bus_if.in_ready), 64'd1);
    check_vec("rst_idx", 64'(bus_if.out_idx), 64'd0);
    check_vec("rst_last", 64'(bus_if.out_last), 64'd0);
    bus_if.in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_vec($sformatf("idle_valid%0d", i), 64'(bus_if.out_valid), 64'd0);
    end

    // Single line 0..7.
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = mk_line(64'h0);
    #1;
    check_vec("single_rdy", 64'(bus_if.in_ready), 64'd1);
    step();
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_beat("single", i, 64'h0, i == 7);
      step();
    end
    check_vec("single_done", 64'(bus_if.out_valid), 64'd0);

    // Three lines back-to-back: 24 beats, no gaps.
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = mk_line(64'hB2B0_0000_0000_0000);
    #1;
    check_vec("b2b_rdy_init", 64'(bus_if.in_ready), 64'd1);
    step();
    for (int b = 0; b < 24; b++) begin
      ln = b / 8;
      k  = b % 8;
      t  = 64'hB2B0_0000_0000_0000 | (64'(ln) << 32);
      if (k == 0) begin
        if (ln < 2) bus_if.in_data = mk_line(64'hB2B0_0000_0000_0000 | (64'(ln + 1) << 32));
        else        bus_if.in_valid = 1'b0;
      end
      check_beat($sformatf("b2b%0d", ln), k, t, k == 7);
      step();
    end
    check_vec("b2b_done", 64'(bus_if.out_valid), 64'd0);

    // Backpressure at beat 3 for 5 cycles.
    t = 64'h5A5A_1234_0000_0100;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = mk_line(t);
    step();
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_beat("bp_pre", i, t, 1'b0);
      step();
    end
    bus_if.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check_beat($sformatf("bp_stall%0d", s), 3, t, 1'b0);
      step();
    end
    bus_if.out_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      check_beat("bp_post", i, t, i == 7);
      step();
    end
    check_vec("bp_done", 64'(bus_if.out_valid), 64'd0);

    // Reset in the middle of a line, then a fresh line.
    t = 64'hAAAA_0000_0000_0000;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = mk_line(t);
    step();
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_vec("mrst_pre_idx", 64'(bus_if.out_idx), 64'd4);
    rst = 1'b1;
    #1;
    check_vec("mrst_valid", 64'(bus_if.out_valid), 64'd0);
    check_vec("mrst_idx", 64'(bus_if.out_idx), 64'd0);
    check_vec("mrst_ready", 64'(bus_if.in_ready), 64'd1);
    step();
    rst = 1'b0;
    step();
    check_vec("mrst_idle", 64'(bus_if.out_valid), 64'd0);
    t = 64'hBEEF_0000_0000_0040;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = mk_line(t);
    step();
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_beat("mrst_new", i, t, i == 7);
      step();
    end
    check_vec("mrst_done", 64'(bus_if.out_valid), 64'd0);

`ifdef LINE_UNPACKER_PERF_CNT_EN
    // Counters were cleared by the mid-line reset: 1 line / 8 beats so far.
    t = 64'hC0C0_0000_0000_0000;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = mk_line(t);
    step();
    bus_if.in_valid = 1'b0;
    step();
    step();
    bus_if.out_ready = 1'b0;
    repeat (4) step();
    bus_if.out_ready = 1'b1;
    repeat (6) step();
    check_vec("perf_done_valid", 64'(bus_if.out_valid), 64'd0);
    check_vec("perf_lines", 64'(perf_lines), 64'd2);
    check_vec("perf_beats", 64'(perf_beats), 64'd16);
    check_vec("perf_stall", 64'(perf_stall), 64'd4);

    force dut.u_perf_cnt.r_perf_stall = 32'hFFFF_FFFE;
    #1;
    release dut.u_perf_cnt.r_perf_stall;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b0;
    step();
    bus_if.in_valid = 1'b0;
    repeat (3) step();
    check_vec("perf_stall_sat", 64'(perf_stall), 64'hFFFF_FFFF);
    bus_if.out_ready = 1'b1;
    repeat (8) step();
    check_vec("perf_sat_drain", 64'(bus_if.out_valid), 64'd0);
    check_vec("perf_stall_hold", 64'(perf_stall), 64'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/line_unpacker.md
Name: line_unpacker

Overview:
- Width down-converter on the read side of the clock-crossing FIFO.
- Accepts one wide line (default 512 b) per valid/ready handshake and emits it as RATIO narrow beats (default 8 x 64 b), least-significant slice first.
- Its in_ready drives the FIFO's read-ready; its output feeds the narrow-datapath consumer.
- Sustains one output beat per cycle with no bubble between consecutive lines.

Parameters:
- IN_WIDTH, 512, width of input line in bits.
- OUT_WIDTH, 64, width of output beat in bits. IN_WIDTH/OUT_WIDTH = RATIO, which must be a power of two >= 2. Elaboration error otherwise.
- IDX_W, $clog2(IN_WIDTH/OUT_WIDTH), width of the beat index.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset: asynchronous, active-high (positive logic).
- in_valid  input  1  input line valid.
- in_ready  output  1  input line accepted when in_valid && in_ready.
- in_data  input  IN_WIDTH  input line.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat when out_valid && out_ready.
- out_data  output  OUT_WIDTH  current beat.
- out_idx  output  IDX_W  index of current beat within line, 0..RATIO-1.
- out_last  output  1  high on beat RATIO-1.

Behaviour:
- State: busy flag (EMPTY=0 / BUSY=1), hold register hold_q[IN_WIDTH], beat counter cnt_q[IDX_W].
- Reset (async assert, sync-released usage assumed upstream): busy=0, cnt_q=0, so out_valid=0, out_idx=0, out_last=0. hold_q is not reset. out_data is don't-care while out_valid=0.
- out_valid = busy.
- out_idx = cnt_q.
- out_data = hold_q[cnt_q*OUT_WIDTH +: OUT_WIDTH].
- out_last = busy && (cnt_q == RATIO-1).
- fire_out = out_valid && out_ready; fire_in = in_valid && in_ready.
- in_ready = ~busy || (fire_out && out_last). This is combinational from out_ready. There is no path from in_valid to in_ready.
- EMPTY: on fire_in, load hold_q=in_data, cnt_q=0, go to BUSY. Latency is 1 cycle from accept to out_valid.
- BUSY, fire_out && !out_last: cnt_q++, hold_q is kept.
- BUSY, fire_out && out_last && fire_in: load new line, cnt_q=0, stay BUSY. This is the zero-bubble case.
- BUSY, fire_out && out_last && !fire_in: cnt_q=0, go to EMPTY.
- BUSY, !fire_out: all state held. out_data, out_idx and out_last are stable while out_valid && !out_ready.
- cnt_q wraps from RATIO-1 to 0 only via the transitions above. Natural overflow is never relied on.
- Throughput: a line every RATIO cycles when out_ready stays high and in_valid stays high.
- rst asserted mid-line: the partial line is discarded, outputs return to reset values immediately (async), and nothing is replayed.
- Simulation-only checks (translate_off):
  - $display and $finish if in_data is accepted while busy && !(fire_out && out_last). This would be an internal overwrite.
  - $display and $finish if out_valid drops without fire_out.

Optional Feature:
- Macro: LINE_UNPACKER_PERF_CNT_EN.
- With the macro defined, three extra output ports are added:
  - perf_lines[31:0]: count of fire_in.
  - perf_beats[31:0]: count of fire_out.
  - perf_stall[31:0]: cycles with out_valid && !out_ready.
- All three reset to 0 on rst and saturate at 32'hFFFF_FFFF with no wrap.
- Without the macro the ports and counters are absent and the datapath is identical.

Decomposition:
- Package line_unpacker_pkg: localparam PERF_CNT_W=32, typedef logic [PERF_CNT_W-1:0] perf_cnt_t, and a saturating-increment function.
- One sub-module: line_unpacker_perf_cnt. It holds the three saturating counters, is instantiated only under LINE_UNPACKER_PERF_CNT_EN, and has inputs clk, rst, fire_in, fire_out, stall.
- Core FSM and datapath stay in line_unpacker.

Test Plan:
- Reset: rst=1 with in_valid=1 -> out_valid=0, in_ready=1, out_idx=0. After release, no beat appears until the first handshake.
- Single line: in_data = {64'h7,...,64'h1,64'h0}, out_ready=1 -> out_valid rises 1 cycle after accept. out_data is 0,1,...,7 on consecutive cycles, out_idx 0..7, out_last only on beat 7, then out_valid=0.
- Back-to-back: three lines offered continuously, out_ready=1 -> 24 consecutive beats with no gap. in_ready is high only in cycles where out_last fires, plus the initial empty cycle.
- Backpressure: out_ready=0 for 5 cycles at beat 3 -> out_data, out_idx=3 and out_last=0 stay frozen. in_ready=0 throughout. Resume gives beats 3..7 in order.
- Mid-line reset: assert rst at beat 4 -> out_valid=0 in the same cycle. The next accepted line starts at out_idx=0 with its own data, and there is no residue of the old line.
- Perf (macro on): 2 lines, 4 stall cycles -> perf_lines=2, perf_beats=16, perf_stall=4. Preload perf_stall near max with force -> it holds at 32'hFFFF_FFFF.
